// File: rtl/div_seq_pkg.sv
// Shared constants for the sequential divider: FSM state encodings and DIV/IDIV func codes.
// The ALU decode and the microcode sequencer use the same values.
package div_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic FUNC_DIV  = 1'b0;
    localparam logic FUNC_IDIV = 1'b1;

    localparam logic [4:0] ITER_WORD = 5'd16;
    localparam logic [4:0] ITER_BYTE = 5'd8;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division step: shift {R,Q} left by one, trial-subtract D from R,
// keep the difference and set the new quotient bit when it does not go negative.
module div_step (
    input  logic [15:0] r,
    input  logic [15:0] q,
    input  logic [15:0] d,
    output logic [15:0] r_next,
    output logic [15:0] q_next
);

    logic [16:0] shifted;
    logic [16:0] trial;

    assign shifted = {r, q[15]};
    assign trial   = shifted - {1'b0, d};
    // R < D holds on entry, so both outcomes fit back into 16 bits.
    assign r_next  = trial[16] ? shifted[15:0] : trial[15:0];
    assign q_next  = {q[14:0], ~trial[16]};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/IDIV sequencer (8/16-bit), one quotient bit per clock.
// Signed IDIV support is compiled in only when DIV_SIGNED_EN is defined.
module div_seq
    import div_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        func,
    input  logic        word_op,
    input  logic [31:0] x,
    input  logic [15:0] y,
    output logic [31:0] out,
    output logic        busy,
    output logic        done,
    output logic        div_exc
);

    state_t      state;
    logic [31:0] lx;
    logic [15:0] ly;
    logic        lword;
    logic [15:0] rem, quo, dvs;
    logic [4:0]  cnt;
    logic [15:0] r_next, q_next;

    logic [31:0] mag_x;
    logic [15:0] mag_y, hi_x;
    logic        load_exc, fix_exc;
    logic [15:0] q_res, r_res;
    logic [31:0] result;

`ifdef DIV_SIGNED_EN
    logic        lfunc, sx, sy, neg_x, neg_y, q_neg;
    logic [15:0] q_mag, lim;

    always_comb begin
        neg_x = (lfunc == FUNC_IDIV) && (lword ? lx[31] : lx[15]);
        neg_y = (lfunc == FUNC_IDIV) && (lword ? ly[15] : ly[7]);
        if (lword) begin
            mag_x = neg_x ? -lx : lx;
            mag_y = neg_y ? -ly : ly;
        end else begin
            mag_x = {16'd0, (neg_x ? -lx[15:0] : lx[15:0])};
            mag_y = {8'd0, (neg_y ? -ly[7:0] : ly[7:0])};
        end
    end

    // Signed quotient range: up to 2^(N-1)-1 positive, 2^(N-1) negative.
    always_comb begin
        q_mag   = lword ? quo : {8'd0, quo[7:0]};
        q_neg   = sx ^ sy;
        lim     = lword ? 16'h8000 : 16'h0080;
        fix_exc = (lfunc == FUNC_IDIV) && (q_neg ? (q_mag > lim) : (q_mag >= lim));
        q_res   = q_neg ? -q_mag : q_mag;
        r_res   = sx ? -rem : rem;
    end
`else
    logic unused_func;
    assign unused_func = func;

    always_comb begin
        mag_x   = lword ? lx : {16'd0, lx[15:0]};
        mag_y   = lword ? ly : {8'd0, ly[7:0]};
        fix_exc = 1'b0;
        q_res   = quo;
        r_res   = rem;
    end
`endif

    assign hi_x     = lword ? mag_x[31:16] : {8'd0, mag_x[15:8]};
    // Zero divisor, or a quotient that cannot fit in N bits.
    assign load_exc = (mag_y == 16'd0) || (hi_x >= mag_y);
    assign result   = lword ? {r_res, q_res} : {16'd0, r_res[7:0], q_res[7:0]};

    div_step u_step (
        .r      (rem),
        .q      (quo),
        .d      (dvs),
        .r_next (r_next),
        .q_next (q_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out     <= 32'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            div_exc <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    lx      <= x;
                    ly      <= y;
                    lword   <= word_op;
`ifdef DIV_SIGNED_EN
                    lfunc   <= func;
`endif
                    busy    <= 1'b1;
                    div_exc <= 1'b0;
                    state   <= LOAD;
                end
                LOAD: begin
                    // Byte dividends sit in the top of Q so Q[15] is always the next bit in.
                    rem <= hi_x;
                    quo <= lword ? mag_x[15:0] : {mag_x[7:0], 8'h00};
                    dvs <= mag_y;
                    cnt <= lword ? ITER_WORD : ITER_BYTE;
`ifdef DIV_SIGNED_EN
                    sx  <= neg_x;
                    sy  <= neg_y;
`endif
                    if (load_exc) begin
                        out     <= 32'd0;
                        div_exc <= 1'b1;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state   <= ITER;
                    end
                end
                ITER: begin
                    rem <= r_next;
                    quo <= q_next;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) state <= FIX;
                end
                FIX: begin
                    out     <= fix_exc ? 32'd0 : result;
                    div_exc <= fix_exc;
                    done    <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
